// File: rtl/beer_pkg.sv
// beer_pkg: display codes, meter FSM codes and counter widths shared by the pour meter
package beer_pkg;
  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_FOAM = 2'd1;
  localparam logic [1:0] S_BEER = 2'd2;
  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_POUR = 2'd1;
  localparam logic [1:0] M_DONE = 2'd2;
  localparam int CL_W  = 8;
  localparam int KEG_W = 16;
endpackage

// File: rtl/cl_prescaler.sv
// cl_prescaler: divides valve-open edges into centilitre ticks (clk, reset, en, sclr in; cl_tick out)
module cl_prescaler #(
  parameter int TICKS_PER_CL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sclr,
  output logic cl_tick
);
  localparam int W = TICKS_PER_CL > 1 ? $clog2(TICKS_PER_CL) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_CL - 1);
  logic [W-1:0] r_tick_cnt;
  // sclr also suppresses the tick so a clear wins over a completing centilitre
  assign cl_tick = en && !sclr && r_tick_cnt == LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_tick_cnt <= '0;
    else if (sclr) r_tick_cnt <= '0;
    else if (en) r_tick_cnt <= cl_tick ? '0 : r_tick_cnt + 1'b1;
endmodule

// File: rtl/beer_pour_meter.sv
// beer_pour_meter: converts valve-open time to cl, counts qualified pours, tracks keg use and sequence errors
// in: clk, reset, beer, state_display, clear; out: pour_done, pour_count, last_pour_cl, keg_used, keg_empty, seq_error, fsm_state
module beer_pour_meter
  import beer_pkg::*;
#(
  parameter int TICKS_PER_CL = 4,
  parameter int MIN_POUR_CL  = 2,
  parameter int KEG_CL       = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beer,
  input  logic [1:0]       state_display,
  input  logic             clear,
  output logic             pour_done,
  output logic [CL_W-1:0]  pour_count,
  output logic [CL_W-1:0]  last_pour_cl,
  output logic [KEG_W-1:0] keg_used,
  output logic             keg_empty,
  output logic             seq_error,
  output logic [1:0]       fsm_state
);
  localparam logic [CL_W-1:0]  MIN_CL  = CL_W'(MIN_POUR_CL);
  localparam logic [KEG_W-1:0] KEG_LIM = KEG_W'(KEG_CL);
  logic [1:0]       r_state;
  logic [CL_W-1:0]  r_pour_cl;
  logic [CL_W-1:0]  r_pour_count;
  logic [CL_W-1:0]  r_last_pour_cl;
  logic [KEG_W-1:0] r_keg_used;
  logic             r_pour_done;
  logic             r_seq_error;
  logic             w_enter_done;
  logic             w_qualified;
  logic             w_cl_tick;
  logic [1:0]       w_next_state;
  assign w_enter_done = r_state == M_POUR && !beer;
  assign w_qualified  = r_pour_cl >= MIN_CL;
  // an open valve always leads to POUR; only a closing POUR passes through DONE
  always_comb w_next_state = beer ? M_POUR : (r_state == M_POUR ? M_DONE : M_IDLE);
  cl_prescaler #(.TICKS_PER_CL(TICKS_PER_CL)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (beer),
    .sclr   (clear || w_enter_done),
    .cl_tick(w_cl_tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset || clear) begin
      r_state        <= M_IDLE;
      r_pour_cl      <= '0;
      r_pour_count   <= '0;
      r_last_pour_cl <= '0;
      r_keg_used     <= '0;
      r_pour_done    <= 1'b0;
      r_seq_error    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pour_done <= w_enter_done && w_qualified;
      r_pour_cl   <= w_enter_done ? '0 : (w_cl_tick && !(&r_pour_cl)) ? r_pour_cl + 1'b1 : r_pour_cl;
      if (w_cl_tick && !(&r_keg_used)) r_keg_used <= r_keg_used + 1'b1;
      if (w_enter_done && w_qualified) begin
        r_last_pour_cl <= r_pour_cl;
        if (!(&r_pour_count)) r_pour_count <= r_pour_count + 1'b1;
      end
      if (beer && state_display != S_BEER) r_seq_error <= 1'b1;
    end
  assign pour_done    = r_pour_done;
  assign pour_count   = r_pour_count;
  assign last_pour_cl = r_last_pour_cl;
  assign keg_used     = r_keg_used;
  assign keg_empty    = r_keg_used >= KEG_LIM;
  assign seq_error    = r_seq_error;
  assign fsm_state    = r_state;
endmodule
